mem_bus_slave: RTL and testbench
================================

// Module: mem_bus_slave
// PURPOSE
// - Synthesisable, parametrised memory slave for the CPU's memRWPin/memOpDone bus; successor to the bench-only memory model.
// - Adds an explicit request strobe, programmable wait states, a multi-cycle done pulse, out-of-range error reporting and a registered, tri-stated read path.
// - Sits between the cpu and on-chip RAM; the same block serves as the bench memory.
// PARAMETERS
// - DATA_W      32  data bus width in bits
// - ADDR_W      32  address bus width in bits
// - DEPTH       1024  number of DATA_W words stored
// - WAIT_CYCLES 2   cycles between accept and memOpDone; 0 allowed
// - DONE_CYCLES 1   cycles memOpDone stays high; 1 or more
// PORTS
// - clk         in     1       system clock, rising-edge
// - reset       in     1       asynchronous, active-low reset
// - memReq      in     1       CPU request valid; held high until memOpDone seen
// - memRWPin    in     1       1: write (CPU drives dataBus), 0: read
// - addressBus  in     ADDR_W  byte address; word index = addressBus >> 2
// - dataBus     inout  DATA_W  driven by slave only during read completion, else 'z
// - memOpDone   out    1       transfer complete
// - memErr      out    1       valid with memOpDone; 1 = word index >= DEPTH
// BEHAVIOUR
// - Reset (async, reset==0): state IDLE, memOpDone=0, memErr=0, dataBus released ('z), counters 0.
// - Reset does not clear RAM contents.
// - FSM: IDLE -> WAIT -> DONE -> HOLD -> IDLE.
// - IDLE: on a clk edge with memReq=1, latch memRWPin, addressBus and (for writes) dataBus.
//   - Go to WAIT with counter = WAIT_CYCLES.
//   - If WAIT_CYCLES==0, go straight to DONE.
// - WAIT: decrement each cycle; at 0 go to DONE.
//   - Write: RAM update (if in range) occurs on the WAIT->DONE edge.
//   - Read: RAM output registered on the same edge.
//   - Request contents are fixed at accept; later changes on the CPU pins are ignored.
// - DONE: memOpDone=1 for exactly DONE_CYCLES cycles.
//   - memErr reflects the range check over the same cycles.
//   - Read: dataBus driven with read data from the first DONE cycle until HOLD exits.
// - HOLD: memOpDone=0; wait for memReq=0, then IDLE and release dataBus.
//   - A new request needs memReq low for at least one cycle (no back-to-back without deassert).
// - Latency, accept edge to memOpDone high: WAIT_CYCLES+1 clocks.
// - Out of range (index >= DEPTH):
//   - Write is dropped, RAM unchanged.
//   - Read drives all-zero data.
//   - memErr=1.
// - Index arithmetic uses the low $clog2(DEPTH) bits of the word index for the RAM port.
//   - The range check uses the full ADDR_W-2 bits, so there is no aliasing or wrap.
// - memReq dropped before memOpDone: the transfer still completes internally.
//   - memOpDone is still pulsed, then HOLD exits immediately.
// - Reset mid-operation: FSM aborts to IDLE at once.
//   - A write whose commit edge has not occurred is lost.
//   - A committed write persists.
// - Slave never drives dataBus while the latched op is a write: no bus contention.
// STRUCTURE
// - Shared include mem_bus_defs.vh: FSM state encodings (IDLE/WAIT/DONE/HOLD) and the bus op codes (OP_READ=0, OP_WRITE=1).
// - Sub-module mem_bus_ram: single-port synchronous RAM with DEPTH x DATA_W array, we, addr, wdata and registered rdata; no reset on the array.
// - Top level holds the FSM, wait/done counters, request latches, range check and tri-state driver.
// TESTING
// - Write then read, defaults:
//   - Write 0xDEADBEEF to addr 0x10 -> memOpDone high 3 clocks after accept, memErr=0.
//   - Read addr 0x10 -> dataBus=0xDEADBEEF during DONE/HOLD, 'z after memReq drops.
// - WAIT_CYCLES=0, DONE_CYCLES=3: read -> memOpDone high on the 1st clock after accept for exactly 3 cycles.
// - Out of range, DEPTH=1024:
//   - Write 0x1234 to addr 0x1000 -> memErr=1; a following read of addr 0x0 returns the prior value.
//   - Read of addr 0x1000 -> data 0, memErr=1.
// - Reset in WAIT: assert reset=0 mid-write of 0xAAAA5555 to 0x20 -> memOpDone=0 immediately, dataBus 'z, later read of 0x20 returns the old value.
// - Early deassert: memReq dropped 1 cycle after accept -> memOpDone still pulses once, FSM back in IDLE one cycle later.
// - Latch check:
//   - Change addressBus/dataBus during WAIT of a write to 0x8 -> only 0x8 is updated with the accept-time data.
//   - memReq held high through HOLD -> no second transfer.

Source files
------------

// File: rtl/mem_bus_slave_pkg.sv
// Shared types and helpers for the memory bus slave: FSM states, bus op codes,
// counter sizing.
package mem_bus_slave_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2,
    StHold = 2'd3
  } state_e;

  localparam logic OpRead  = 1'b0;
  localparam logic OpWrite = 1'b1;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port synchronous RAM with registered read data; the array has no reset
// so contents survive a bus reset.
module mem_bus_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_slave.sv
// Memory slave for the CPU memRWPin/memOpDone bus: latched request, programmable
// wait states, multi-cycle done pulse, range error and tri-stated read data.
module mem_bus_slave
  import mem_bus_slave_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DONE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memReq,
  input  logic              memRWPin,
  input  logic [ADDR_W-1:0] addressBus,
  inout  wire  [DATA_W-1:0] dataBus,
  output logic              memOpDone,
  output logic              memErr
);

  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WordW  = ADDR_W - 2;
  localparam int unsigned WaitW  = cnt_width(WAIT_CYCLES);
  localparam int unsigned DoneW  = cnt_width(DONE_CYCLES);

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DoneW-1:0]   done_cnt_q, done_cnt_d;
  logic               op_q, err_q;
  logic [IdxW-1:0]    idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               commit, accept, drive;
  logic [WordW-1:0]   live_word;
  logic               live_oor;
  logic               sel_op, sel_oor;
  logic [IdxW-1:0]    sel_idx;
  logic [DATA_W-1:0]  sel_wdata, ram_rdata;
  logic               unused_addr_lsb;

  assign live_word       = addressBus[ADDR_W-1:2];
  assign live_oor        = (live_word >= WordW'(DEPTH));
  assign unused_addr_lsb = ^addressBus[1:0];
  assign accept          = (state_q == StIdle) && memReq;

  // With zero wait states the commit edge is the accept edge, so the RAM must
  // see the live bus rather than the (not yet loaded) request latches.
  assign sel_op    = (state_q == StIdle) ? memRWPin : op_q;
  assign sel_oor   = (state_q == StIdle) ? live_oor : err_q;
  assign sel_idx   = (state_q == StIdle) ? live_word[IdxW-1:0] : idx_q;
  assign sel_wdata = (state_q == StIdle) ? dataBus : wdata_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    done_cnt_d = done_cnt_q;
    commit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (memReq) begin
          if (WAIT_CYCLES == 0) begin
            commit     = 1'b1;
            state_d    = StDone;
            done_cnt_d = DoneW'(DONE_CYCLES);
          end else begin
            state_d    = StWait;
            wait_cnt_d = WaitW'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q - WaitW'(1);
        if (wait_cnt_q <= WaitW'(1)) begin
          commit     = 1'b1;
          state_d    = StDone;
          done_cnt_d = DoneW'(DONE_CYCLES);
        end
      end
      StDone: begin
        done_cnt_d = done_cnt_q - DoneW'(1);
        if (done_cnt_q <= DoneW'(1)) state_d = StHold;
      end
      StHold: begin
        if (!memReq) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      done_cnt_q <= '0;
      op_q       <= OpRead;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      done_cnt_q <= done_cnt_d;
      if (accept) begin
        op_q    <= memRWPin;
        err_q   <= live_oor;
        idx_q   <= live_word[IdxW-1:0];
        wdata_q <= dataBus;
      end
    end
  end

  mem_bus_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IdxW)
  ) u_ram (
    .clk   (clk),
    .we    (commit && (sel_op == OpWrite) && !sel_oor),
    .re    (commit && (sel_op == OpRead)),
    .addr  (sel_idx),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  assign memOpDone = (state_q == StDone);
  assign memErr    = memOpDone && err_q;
  assign drive     = (op_q == OpRead) && ((state_q == StDone) || (state_q == StHold));
  assign dataBus   = drive ? (err_q ? '0 : ram_rdata) : 'z;

endmodule

// File: tb/tb_mem_bus_slave.sv
// Self-checking bench for mem_bus_slave: directed scenarios plus randomized
// traffic checked against an associative-array memory model.
module tb_mem_bus_slave;
  import mem_bus_slave_pkg::*;

  localparam int unsigned Depth = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, rw, z_req, z_rw;
  logic [31:0] addr, z_addr, drv;
  logic        drv_en, z_drv_en;
  wire  [31:0] bus, z_bus;
  logic        done, err, z_done, z_err;
  logic [31:0] zval;

  int passed = 0;
  int total  = 0;
  logic [31:0] model [int unsigned];

  assign bus   = drv_en   ? drv : 'z;
  assign z_bus = z_drv_en ? drv : 'z;

  always #5 clk = ~clk;

  mem_bus_slave dut (
    .clk        (clk),
    .reset      (rst_n),
    .memReq     (req),
    .memRWPin   (rw),
    .addressBus (addr),
    .dataBus    (bus),
    .memOpDone  (done),
    .memErr     (err)
  );

  mem_bus_slave #(
    .WAIT_CYCLES (0),
    .DONE_CYCLES (3)
  ) dut_z (
    .clk        (clk),
    .reset      (rst_n),
    .memReq     (z_req),
    .memRWPin   (z_rw),
    .addressBus (z_addr),
    .dataBus    (z_bus),
    .memOpDone  (z_done),
    .memErr     (z_err)
  );

  // Full handshake; entered and left on a negedge with the slave idle.
  task automatic xfer(input bit sel, input logic op, input logic [31:0] a,
                      input logic [31:0] wd, output int lat, output int ndone,
                      output logic e, output logic [31:0] rd,
                      output logic [31:0] hold_rd, output logic [31:0] rel_rd);
    if (sel) begin z_req = 1'b1; z_rw = op; z_addr = a; z_drv_en = op; end
    else begin req = 1'b1; rw = op; addr = a; drv_en = op; end
    drv = wd;
    lat = 0; ndone = 0; e = 1'b0; rd = '0;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (sel ? z_done : done) begin lat = k; break; end
    end
    while ((sel ? z_done : done) && ndone < 40) begin
      ndone++;
      e = e | (sel ? z_err : err);
      if (ndone == 1) rd = sel ? z_bus : bus;
      @(negedge clk);
    end
    hold_rd = sel ? z_bus : bus;
    if (sel) begin z_req = 1'b0; z_drv_en = 1'b0; end
    else begin req = 1'b0; drv_en = 1'b0; end
    @(negedge clk);
    rel_rd = sel ? z_bus : bus;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    total++; if (bus !== zval) $display("FAIL reset_bus: got %h want z", bus); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat, nd; logic e; logic [31:0] rd, hr, rr;
    xfer(0, OpWrite, 32'h10, 32'hDEADBEEF, lat, nd, e, rd, hr, rr);
    model[4] = 32'hDEADBEEF;
    total++; if (lat !== 3) $display("FAIL wr_latency: got %0d want 3", lat); else passed++;
    total++; if (nd !== 1) $display("FAIL wr_done_len: got %0d want 1", nd); else passed++;
    total++; if (e !== 1'b0) $display("FAIL wr_err: got %b want 0", e); else passed++;
    xfer(0, OpRead, 32'h10, 32'h0, lat, nd, e, rd, hr, rr);
    total++; if (lat !== 3) $display("FAIL rd_latency: got %0d want 3", lat); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else passed++;
    total++; if (hr !== 32'hDEADBEEF) $display("FAIL rd_hold: got %h want deadbeef", hr); else passed++;
    total++; if (rr !== zval) $display("FAIL rd_release: got %h want z", rr); else passed++;
    total++; if (e !== 1'b0) $display("FAIL rd_err: got %b want 0", e); else passed++;
  endtask

  task automatic test_out_of_range();
    int lat, nd; logic e; logic [31:0] rd, hr, rr;
    xfer(0, OpWrite, 32'h0, 32'h0BAD_F00D, lat, nd, e, rd, hr, rr);
    model[0] = 32'h0BAD_F00D;
    xfer(0, OpWrite, 32'h1000, 32'h1234, lat, nd, e, rd, hr, rr);
    total++; if (e !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", e); else passed++;
    xfer(0, OpRead, 32'h0, 32'h0, lat, nd, e, rd, hr, rr);
    total++; if (rd !== model[0]) $display("FAIL oor_no_alias: got %h want %h", rd, model[0]); else passed++;
    xfer(0, OpRead, 32'h1000, 32'h0, lat, nd, e, rd, hr, rr);
    total++; if (rd !== 32'h0) $display("FAIL oor_rd_data: got %h want 0", rd); else passed++;
    total++; if (e !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", e); else passed++;
  endtask

  task automatic test_random();
    int lat, nd; logic e; logic [31:0] rd, hr, rr, a, wd, exp_d;
    int unsigned idx, c; logic op;
    for (int i = 0; i < 40; i++) begin
      c = $urandom_range(0, 9);
      if (c < 6) idx = $urandom_range(0, 15);
      else if (c < 8) idx = $urandom_range(Depth - 8, Depth - 1);
      else if (c < 9) idx = Depth + $urandom_range(0, 15);
      else idx = 32'h3FFF_FFF0 + $urandom_range(0, 15);
      a  = (idx << 2) | 32'($urandom_range(0, 3));
      op = 1'($urandom_range(0, 1));
      if (op == OpRead && idx < Depth && !model.exists(idx)) op = OpWrite;
      wd = $urandom;
      xfer(0, op, a, wd, lat, nd, e, rd, hr, rr);
      total++; if (lat !== 3) $display("FAIL rnd_latency[%0d]: got %0d want 3", i, lat); else passed++;
      total++;
      if (e !== (idx >= Depth)) $display("FAIL rnd_err[%0d]: got %b want %b", i, e, idx >= Depth);
      else passed++;
      if (op == OpWrite) begin
        if (idx < Depth) model[idx] = wd;
      end else begin
        exp_d = (idx >= Depth) ? 32'h0 : model[idx];
        total++; if (rd !== exp_d) $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rd, exp_d); else passed++;
        total++; if (hr !== exp_d) $display("FAIL rnd_hold[%0d]: got %h want %h", i, hr, exp_d); else passed++;
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int lat, nd; logic e; logic [31:0] rd, hr, rr;
    xfer(0, OpWrite, 32'h20, 32'h1357_9BDF, lat, nd, e, rd, hr, rr);
    model[8] = 32'h1357_9BDF;
    req = 1'b1; rw = OpWrite; addr = 32'h20; drv = 32'hAAAA5555; drv_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; drv_en = 1'b0; rst_n = 1'b0;
    #1;
    total++; if (done !== 1'b0) $display("FAIL rst_wait_done: got %b want 0", done); else passed++;
    total++; if (bus !== zval) $display("FAIL rst_wait_bus: got %h want z", bus); else passed++;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    xfer(0, OpRead, 32'h20, 32'h0, lat, nd, e, rd, hr, rr);
    total++; if (rd !== model[8]) $display("FAIL rst_lost_wr: got %h want %h", rd, model[8]); else passed++;
    // Reset after the commit edge must keep the new word.
    req = 1'b1; rw = OpWrite; addr = 32'h24; drv = 32'h600D_CAFE; drv_en = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    req = 1'b0; drv_en = 1'b0; rst_n = 1'b0;
    #1;
    total++; if (done !== 1'b0) $display("FAIL rst_done_done: got %b want 0", done); else passed++;
    model[9] = 32'h600D_CAFE;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    xfer(0, OpRead, 32'h24, 32'h0, lat, nd, e, rd, hr, rr);
    total++; if (rd !== model[9]) $display("FAIL rst_kept_wr: got %h want %h", rd, model[9]); else passed++;
  endtask

  task automatic test_early_deassert();
    int lat, nd, pulses, first; logic e; logic [31:0] rd, hr, rr, wd;
    wd = $urandom;
    req = 1'b1; rw = OpWrite; addr = 32'h30; drv = wd; drv_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; drv_en = 1'b0;
    first = 0;
    for (int k = 2; k <= 40; k++) begin
      if (done) begin first = k - 1; break; end
      @(negedge clk);
    end
    total++; if (first !== 3) $display("FAIL early_latency: got %0d want 3", first); else passed++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (dut.state_q !== StIdle) $display("FAIL early_idle: got %0d want %0d", dut.state_q, StIdle);
    else passed++;
    pulses = 1;
    for (int k = 0; k < 6; k++) begin if (done) pulses++; @(negedge clk); end
    total++; if (pulses !== 1) $display("FAIL early_pulses: got %0d want 1", pulses); else passed++;
    model[12] = wd;
    xfer(0, OpRead, 32'h30, 32'h0, lat, nd, e, rd, hr, rr);
    total++; if (rd !== wd) $display("FAIL early_commit: got %h want %h", rd, wd); else passed++;
  endtask

  task automatic test_latch();
    int lat, nd, pulses; logic e; logic [31:0] rd, hr, rr, v8, vc;
    v8 = $urandom; vc = $urandom;
    xfer(0, OpWrite, 32'hC, vc, lat, nd, e, rd, hr, rr);
    model[3] = vc;
    req = 1'b1; rw = OpWrite; addr = 32'h8; drv = v8; drv_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    addr = 32'hC; drv = ~v8;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin @(negedge clk); if (done) pulses++; end
    total++; if (pulses !== 1) $display("FAIL latch_pulses: got %0d want 1", pulses); else passed++;
    req = 1'b0; drv_en = 1'b0;
    @(negedge clk); @(negedge clk);
    model[2] = v8;
    xfer(0, OpRead, 32'h8, 32'h0, lat, nd, e, rd, hr, rr);
    total++; if (rd !== v8) $display("FAIL latch_addr8: got %h want %h", rd, v8); else passed++;
    xfer(0, OpRead, 32'hC, 32'h0, lat, nd, e, rd, hr, rr);
    total++; if (rd !== vc) $display("FAIL latch_addrC: got %h want %h", rd, vc); else passed++;
  endtask

  task automatic test_zero_wait();
    int lat, nd; logic e; logic [31:0] rd, hr, rr, v;
    v = $urandom;
    xfer(1, OpWrite, 32'h40, v, lat, nd, e, rd, hr, rr);
    total++; if (lat !== 1) $display("FAIL zw_wr_latency: got %0d want 1", lat); else passed++;
    total++; if (nd !== 3) $display("FAIL zw_wr_done_len: got %0d want 3", nd); else passed++;
    xfer(1, OpRead, 32'h40, 32'h0, lat, nd, e, rd, hr, rr);
    total++; if (lat !== 1) $display("FAIL zw_rd_latency: got %0d want 1", lat); else passed++;
    total++; if (nd !== 3) $display("FAIL zw_rd_done_len: got %0d want 3", nd); else passed++;
    total++; if (rd !== v) $display("FAIL zw_rd_data: got %h want %h", rd, v); else passed++;
    total++; if (hr !== v) $display("FAIL zw_rd_hold: got %h want %h", hr, v); else passed++;
    total++; if (rr !== zval) $display("FAIL zw_rd_release: got %h want z", rr); else passed++;
    total++; if (e !== 1'b0) $display("FAIL zw_rd_err: got %b want 0", e); else passed++;
  endtask

  initial begin
    zval = 'z;
    rst_n = 1'b0;
    req = 1'b0; rw = 1'b0; addr = '0; drv = '0; drv_en = 1'b0;
    z_req = 1'b0; z_rw = 1'b0; z_addr = '0; z_drv_en = 1'b0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_random();
    test_reset_in_wait();
    test_early_deassert();
    test_latch();
    test_zero_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
